// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and helpers for the dmem arbiter: bus widths, owner
// encoding and the wait-counter sizing function.
package dmem_arbiter_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   localparam logic OWN_PROC = 1'b0;
   localparam logic OWN_PER  = 1'b1;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   // Bits needed to hold 0..max_wait inclusive.
   function automatic int cnt_width(input int max_wait);
      return $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of processor, peripheral and dmem signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if
   import dmem_arbiter_pkg::*;
   ();

   logic  proc_req;
   logic  proc_wren;
   addr_t proc_addr;
   data_t proc_wdata;
   data_t proc_q;
   logic  proc_stall;

   logic  per_req;
   logic  per_wren;
   addr_t per_addr;
   data_t per_wdata;
   logic  per_gnt;
   logic  per_rvalid;
   data_t per_rdata;
   logic  per_err;

   addr_t dmem_address;
   data_t dmem_data;
   logic  dmem_wren;
   data_t dmem_q;

   modport slave (
      input  proc_req, proc_wren, proc_addr, proc_wdata,
      output proc_q, proc_stall,
      input  per_req, per_wren, per_addr, per_wdata,
      output per_gnt, per_rvalid, per_rdata, per_err,
      output dmem_address, dmem_data, dmem_wren,
      input  dmem_q
   );

   modport master (
      output proc_req, proc_wren, proc_addr, proc_wdata,
      input  proc_q, proc_stall,
      output per_req, per_wren, per_addr, per_wdata,
      input  per_gnt, per_rvalid, per_rdata, per_err,
      input  dmem_address, dmem_data, dmem_wren,
      output dmem_q
   );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the peripheral has lost arbitration;
// starve_o forces the next grant to the peripheral.
module arb_starve_counter
   import dmem_arbiter_pkg::*;
#(
   parameter  int MAX_WAIT = 8,
   localparam int CNT_W    = cnt_width(MAX_WAIT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic             starve_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             starve;

   assign starve = (cnt_q == MAX_C);

   always_comb begin
      // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !starve) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks keep all registers sampling pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starve_o = starve;
   assign cnt_o    = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: the processor wins by default, the peripheral is
// forced in after MAX_WAIT lost cycles, and low-address peripheral writes are rejected.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int    MAX_WAIT  = 8,
   parameter addr_t PROT_BASE = '0
) (
   input logic           clock,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   localparam int CNT_W = cnt_width(MAX_WAIT);

   logic             starve;
   logic             per_sel;
   logic             prot_hit;
   logic             blocked;
   logic             owner;
   logic [CNT_W-1:0] wait_cnt;

   logic  rvalid_q, rvalid_d;
   logic  err_q, err_d;
   data_t rdata_q, rdata_d;

   // Protection compare only exists when a boundary is configured.
   if (PROT_BASE == '0) begin : g_no_prot
      assign prot_hit = 1'b0;
   end else begin : g_prot
      assign prot_hit = (bus.per_addr < PROT_BASE);
   end

   assign blocked = bus.per_wren & prot_hit;
   assign per_sel = reset & bus.per_req & (~bus.proc_req | starve);
   assign owner   = per_sel ? OWN_PER : OWN_PROC;

   arb_starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk      (clock),
      .rst_n    (reset),
      .clr_i    (per_sel | ~bus.per_req),
      .inc_i    (bus.per_req & ~per_sel),
      .starve_o (starve),
      .cnt_o    (wait_cnt)
   );

   always_comb begin
      bus.dmem_address = bus.proc_addr;
      bus.dmem_data    = bus.proc_wdata;
      bus.dmem_wren    = bus.proc_req & bus.proc_wren;
      if (owner == OWN_PER) begin
         bus.dmem_address = bus.per_addr;
         bus.dmem_data    = bus.per_wdata;
         bus.dmem_wren    = bus.per_wren & ~blocked;
      end
      // Reset must never let a stray store reach memory.
      if (!reset) begin
         bus.dmem_wren = 1'b0;
      end
   end

   assign bus.proc_q     = bus.dmem_q;
   assign bus.proc_stall = bus.proc_req & per_sel;
   assign bus.per_gnt    = per_sel;

   // dmem is clocked on the falling edge, so dmem_q already holds the
   // granted read by the end of the issuing cycle.
   always_comb begin
      rvalid_d = per_sel & ~bus.per_wren;
      err_d    = per_sel & blocked;
      rdata_d  = rdata_q;
      if (rvalid_d) begin
         rdata_d = bus.dmem_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.per_rvalid = rvalid_q;
   assign bus.per_err    = err_q;
   assign bus.per_rdata  = rdata_q;

endmodule
